// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types, widths and byte-lane merge helper for the Wishbone register bridge
//
// Purpose : FSM state encoding, Wishbone data/select widths, and the lane
//           merge used to turn partial writes into read-modify-write.
// Ports   : none (package)

package wb_pkg;

   localparam int WB_DW = 32;
   localparam int WB_SW = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_WR,
      ST_ACK,
      ST_ERR
   } wb_state_t;

   // Lane n of the result comes from new_data when sel[n] is set, else old_data.
   function automatic logic [WB_DW-1:0] byte_merge(
      input logic [WB_DW-1:0] old_data,
      input logic [WB_DW-1:0] new_data,
      input logic [WB_SW-1:0] sel
   );
      logic [WB_DW-1:0] merged;
      merged = old_data;
      for (int n = 0; n < WB_SW; n++) begin
         if (sel[n]) begin
            merged[8*n +: 8] = new_data[8*n +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/wb_reg_bridge_if.sv
// rtl/wb_reg_bridge_if.sv - Wishbone classic bus bundle between NoC endpoint and register bridge
//
// Purpose : groups the Wishbone handshake and data signals.
// Modports: slave  - the bridge (receives cyc/stb/we/adr/dat/sel, drives dat_o/ack/err)
//           master - the bus initiator (the reverse directions)

interface wb_reg_bridge_if import wb_pkg::*;;

   logic             wb_cyc_i;
   logic             wb_stb_i;
   logic             wb_we_i;
   logic [31:0]      wb_adr_i;
   logic [WB_DW-1:0] wb_dat_i;
   logic [WB_SW-1:0] wb_sel_i;
   logic [WB_DW-1:0] wb_dat_o;
   logic             wb_ack_o;
   logic             wb_err_o;

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
      output wb_dat_o, wb_ack_o, wb_err_o
   );

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
      input  wb_dat_o, wb_ack_o, wb_err_o
   );

endinterface

// File: rtl/wb_byte_merge.sv
// rtl/wb_byte_merge.sv - combinational byte-lane mux producing peripheral write data
//
// Purpose : merges new write data over the previously read register value.
// Ports   : i_old  - register contents (merge buffer)
//           i_new  - Wishbone write data
//           i_sel  - byte selects, bit n picks i_new lane n
//           o_data - merged word

module wb_byte_merge import wb_pkg::*; (
   input  logic [WB_DW-1:0] i_old,
   input  logic [WB_DW-1:0] i_new,
   input  logic [WB_SW-1:0] i_sel,
   output logic [WB_DW-1:0] o_data
);

   assign o_data = byte_merge(i_old, i_new, i_sel);

endmodule

// File: rtl/wb_reg_bridge.sv
// rtl/wb_reg_bridge.sv - Wishbone classic slave driving a simple peripheral register port
//
// Purpose : decodes an address window, runs a multi-cycle access FSM, turns
//           partial writes into read-modify-write, and returns ack or err.
// Ports   : clk, rst_n   - clock, synchronous active-low reset
//           bus          - Wishbone slave side (cyc/stb/we/adr/dat/sel in, dat/ack/err out)
//           reg_addr_o   - register index to the peripheral (holds last index)
//           reg_wdata_o  - write data to the peripheral (0 outside a write)
//           reg_we_o     - one-cycle peripheral write enable
//           reg_rdata_i  - peripheral combinational read data
//           busy_o       - access in progress

module wb_reg_bridge import wb_pkg::*; #(
   parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
   parameter int          WIN_BITS   = 4,
   parameter int          NUM_REGS   = 2,
   localparam int         REG_ADDR_W = WIN_BITS - 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   wb_reg_bridge_if.slave        bus,
   output logic [REG_ADDR_W-1:0] reg_addr_o,
   output logic [WB_DW-1:0]      reg_wdata_o,
   output logic                  reg_we_o,
   input  logic [WB_DW-1:0]      reg_rdata_i,
   output logic                  busy_o
);

   localparam logic [31:0] WIN_MASK = ~((32'd1 << WIN_BITS) - 32'd1);

   wb_state_t             r_state;
   logic [REG_ADDR_W-1:0] r_reg_addr;
   logic [WB_DW-1:0]      r_dat;
   logic [WB_DW-1:0]      r_merge;
   logic [WB_DW-1:0]      r_rd_data;
   logic [WB_SW-1:0]      r_sel;
   logic                  r_is_wr;
   logic                  r_we;
   logic                  r_ack;
   logic                  r_err;

   logic                  w_req;
   logic                  w_hit;
   logic                  w_bad;
   logic [REG_ADDR_W-1:0] w_idx;
   logic [WB_DW-1:0]      w_merged;

   assign w_req = bus.wb_cyc_i && bus.wb_stb_i;
   assign w_hit = (bus.wb_adr_i & WIN_MASK) == BASE_ADDR;
   assign w_idx = bus.wb_adr_i[WIN_BITS-1:2];
   assign w_bad = (int'(w_idx) >= NUM_REGS) || (bus.wb_adr_i[1:0] != 2'b00);

   wb_byte_merge u_merge (
      .i_old  (r_merge),
      .i_new  (r_dat),
      .i_sel  (r_sel),
      .o_data (w_merged)
   );

   // Routing is decided from the live bus in IDLE (the same values being
   // latched) so that the outputs of the next state are already registered
   // when that state begins: err at cycle 1, reg_we_o at cycle 1 for full writes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_reg_addr <= '0;
         r_dat      <= '0;
         r_merge    <= '0;
         r_rd_data  <= '0;
         r_sel      <= '0;
         r_is_wr    <= 1'b0;
         r_we       <= 1'b0;
         r_ack      <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_we  <= 1'b0;
         r_ack <= 1'b0;
         r_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_req && w_hit) begin
                  r_dat   <= bus.wb_dat_i;
                  r_sel   <= bus.wb_sel_i;
                  r_is_wr <= bus.wb_we_i;
                  if (w_bad) begin
                     r_state <= ST_ERR;
                     r_err   <= 1'b1;
                  end else if (bus.wb_we_i && bus.wb_sel_i == 4'hF) begin
                     r_state    <= ST_WR;
                     r_we       <= 1'b1;
                     r_reg_addr <= w_idx;
                     r_merge    <= '0;
                  end else if (bus.wb_we_i && bus.wb_sel_i == 4'h0) begin
                     r_state <= ST_ACK;
                     r_ack   <= 1'b1;
                  end else begin
                     r_state    <= ST_RD;
                     r_reg_addr <= w_idx;
                  end
               end
            end
            ST_RD: begin
               // Master gave up before anything reached the peripheral.
               if (!bus.wb_cyc_i) begin
                  r_state <= ST_IDLE;
               end else if (r_is_wr) begin
                  r_merge <= reg_rdata_i;
                  r_we    <= 1'b1;
                  r_state <= ST_WR;
               end else begin
                  r_rd_data <= reg_rdata_i;
                  r_ack     <= 1'b1;
                  r_state   <= ST_ACK;
               end
            end
            ST_WR: begin
               // The write is already on the port this cycle; only the ack
               // depends on whether the master is still there.
               if (bus.wb_cyc_i) begin
                  r_ack   <= 1'b1;
                  r_state <= ST_ACK;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_ACK:  r_state <= ST_IDLE;
            ST_ERR:  r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.wb_dat_o = r_rd_data;
   assign bus.wb_ack_o = r_ack;
   assign bus.wb_err_o = r_err;
   assign reg_addr_o   = r_reg_addr;
   assign reg_we_o     = r_we;
   assign reg_wdata_o  = r_we ? w_merged : '0;
   assign busy_o       = (r_state != ST_IDLE);

endmodule
